// File: rtl/raw_window_crop.sv
// raw_window_crop: crops the unpacked CSI raw word stream to a fixed rectangular
// window and records line/frame geometry with sticky short-line/short-frame flags.
module raw_window_crop #(
  parameter int X_START  = 0,
  parameter int X_WIDTH  = 320,
  parameter int Y_START  = 0,
  parameter int Y_HEIGHT = 480,
  parameter int XW       = 12,
  parameter int YW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   data_in,
  input  logic          data_valid,
  input  logic          in_line,
  input  logic          in_frame,
  output logic [15:0]   data_out,
  output logic          data_out_valid,
  output logic          out_line,
  output logic          out_frame,
  output logic [XW-1:0] line_words,
  output logic [YW-1:0] frame_lines,
  output logic          err_short_line,
  output logic          err_short_frame
);

  localparam logic [XW:0]   X_LO   = (XW+1)'(X_START);
  localparam logic [XW:0]   X_SPAN = (XW+1)'(X_WIDTH);
  localparam logic [XW:0]   X_HI   = (XW+1)'(X_START + X_WIDTH);
  localparam logic [YW:0]   Y_LO   = (YW+1)'(Y_START);
  localparam logic [YW:0]   Y_SPAN = (YW+1)'(Y_HEIGHT);
  localparam logic [YW:0]   Y_HI   = (YW+1)'(Y_START + Y_HEIGHT);
  localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
  localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};

  logic          r_in_line_q;
  logic          r_in_frame_q;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [15:0]   r_data_out;
  logic          r_data_out_valid;
  logic          r_out_line;
  logic          r_out_frame;
  logic [XW-1:0] r_line_words;
  logic [YW-1:0] r_frame_lines;
  logic          r_err_short_line;
  logic          r_err_short_frame;

  logic          w_line_start;
  logic          w_line_end;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_y_en;
  logic [XW-1:0] w_x_idx;
  logic [XW-1:0] w_x_inc;
  logic [YW-1:0] w_y_inc;
  logic [YW-1:0] w_frame_len;
  logic [XW:0]   w_x_off;
  logic [YW:0]   w_y_off;
  logic          w_col_ok;
  logic          w_row_ok;

  // Edge detection, window membership and saturating counter increments
  always_comb begin
    w_line_start  = in_line & ~r_in_line_q;
    w_line_end    = ~in_line & r_in_line_q;
    w_frame_start = in_frame & ~r_in_frame_q;
    w_frame_end   = ~in_frame & r_in_frame_q;
    w_y_en        = in_frame | r_in_frame_q;
    w_x_idx       = w_line_start ? {XW{1'b0}} : r_x_cnt;
    if (w_x_idx == X_MAX) begin
      w_x_inc = X_MAX;
    end else begin
      w_x_inc = w_x_idx + XW'(1);
    end
    if (r_y_cnt == Y_MAX) begin
      w_y_inc = Y_MAX;
    end else begin
      w_y_inc = r_y_cnt + YW'(1);
    end
    // Offset from window start wraps high when below it, so one compare covers both bounds.
    w_x_off  = {1'b0, w_x_idx} - X_LO;
    w_y_off  = {1'b0, r_y_cnt} - Y_LO;
    w_col_ok = (w_x_off < X_SPAN);
    w_row_ok = (w_y_off < Y_SPAN);
    if (w_line_end) begin
      w_frame_len = w_y_inc;
    end else begin
      w_frame_len = r_y_cnt;
    end
  end

  // Counters, 1-cycle output pipeline, geometry capture and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_line_q       <= 1'b0;
      r_in_frame_q      <= 1'b0;
      r_x_cnt           <= {XW{1'b0}};
      r_y_cnt           <= {YW{1'b0}};
      r_data_out        <= 16'h0000;
      r_data_out_valid  <= 1'b0;
      r_out_line        <= 1'b0;
      r_out_frame       <= 1'b0;
      r_line_words      <= {XW{1'b0}};
      r_frame_lines     <= {YW{1'b0}};
      r_err_short_line  <= 1'b0;
      r_err_short_frame <= 1'b0;
    end else begin
      r_in_line_q  <= in_line;
      r_in_frame_q <= in_frame;

      if (w_line_end) begin
        r_x_cnt <= {XW{1'b0}};
      end else if (data_valid && in_line) begin
        r_x_cnt <= w_x_inc;
      end else if (w_line_start) begin
        r_x_cnt <= {XW{1'b0}};
      end

      if (w_frame_start) begin
        r_y_cnt <= {YW{1'b0}};
      end else if (w_line_end && w_y_en) begin
        r_y_cnt <= w_y_inc;
      end

      r_data_out_valid <= data_valid & in_line & w_row_ok & w_col_ok;
      if (data_valid) begin
        r_data_out <= data_in;
      end
      r_out_line  <= in_line & w_row_ok;
      r_out_frame <= in_frame;

      if (w_line_end) begin
        r_line_words <= r_x_cnt;
      end
      if (w_frame_end) begin
        r_frame_lines <= w_frame_len;
      end

      // Set has priority over the frame-start clear.
      if (w_line_end && w_row_ok && ({1'b0, r_x_cnt} < X_HI)) begin
        r_err_short_line <= 1'b1;
      end else if (w_frame_start) begin
        r_err_short_line <= 1'b0;
      end
      if (w_frame_end && ({1'b0, w_frame_len} < Y_HI)) begin
        r_err_short_frame <= 1'b1;
      end else if (w_frame_start) begin
        r_err_short_frame <= 1'b0;
      end
    end
  end

  assign data_out        = r_data_out;
  assign data_out_valid  = r_data_out_valid;
  assign out_line        = r_out_line;
  assign out_frame       = r_out_frame;
  assign line_words      = r_line_words;
  assign frame_lines     = r_frame_lines;
  assign err_short_line  = r_err_short_line;
  assign err_short_frame = r_err_short_frame;

endmodule
